// File: rtl/rom_rx_pkg.sv
// Shared definitions for the ROM download receiver and the game loader:
// parser states, default frame marker and filetype bit positions.
package rom_rx_pkg;

  localparam logic [2:0] S_SYNC    = 3'd0;
  localparam logic [2:0] S_TYPE    = 3'd1;
  localparam logic [2:0] S_LEN0    = 3'd2;
  localparam logic [2:0] S_LEN1    = 3'd3;
  localparam logic [2:0] S_LEN2    = 3'd4;
  localparam logic [2:0] S_PAYLOAD = 3'd5;
  localparam logic [2:0] S_CSUM    = 3'd6;
  localparam logic [2:0] S_DRAIN   = 3'd7;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int FT_BIOS = 0;
  localparam int FT_NES  = 1;
  localparam int FT_FDS  = 2;
  localparam int FT_NSF  = 3;

endpackage

// File: rtl/rom_stream_receiver_fifo.sv
// Small byte FIFO with registered read data. Full is judged before the pop,
// so a push arriving on a full FIFO is dropped even if a pop happens.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    pop_data_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count_reg == COUNT_FULL);
  assign empty    = (count_reg == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = pop_data_reg;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      pop_data_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        pop_data_reg <= mem[rd_ptr_reg];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/rom_stream_receiver.sv
// Parses framed ROM downloads from an unpaced byte source and replays the
// payload to the loader as paced indata_clk strobes inside a downloading window.
module rom_stream_receiver
  import rom_rx_pkg::*;
#(
  parameter int         MIN_GAP    = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter int         TIMEOUT    = 2_000_000,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        loader_reset,
  output logic        downloading,
  output logic [7:0]  filetype,
  output logic        is_bios,
  output logic [7:0]  indata,
  output logic        indata_clk,
  output logic        frame_error,
  output logic        overflow,
  output logic [23:0] bytes_left
);

  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(MIN_GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic [2:0]    state_reg;
  logic [23:0]   bytes_left_reg;
  logic [7:0]    sum_reg;
  logic [7:0]    filetype_reg;
  logic          loader_reset_reg;
  logic          downloading_reg;
  logic          frame_error_reg;
  logic          overflow_reg;
  logic          indata_clk_reg;
  logic [GW-1:0] gap_reg;
  logic [IW-1:0] idle_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          gap_ok;
  logic          timeout_hit;
  logic [23:0]   len_full;

  assign gap_ok      = (gap_reg >= GAP_MAX);
  assign fifo_pop    = !fifo_empty && downloading_reg && gap_ok;
  assign fifo_push   = (state_reg == S_PAYLOAD) && rx_valid;
  assign len_full    = {bytes_left_reg[15:0], rx_data};
  // A byte arriving in the same cycle wins over an expiring idle count.
  assign timeout_hit = !rx_valid && (idle_reg == IDLE_MAX) &&
                       (state_reg != S_SYNC) && (state_reg != S_DRAIN);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .pop_data  (indata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_reg        <= GAP_MAX;
      idle_reg       <= '0;
      indata_clk_reg <= 1'b0;
    end else begin
      indata_clk_reg <= fifo_pop;
      if (fifo_pop)             gap_reg <= GAP_ONE;
      else if (!gap_ok)         gap_reg <= gap_reg + 1'b1;
      if (rx_valid)             idle_reg <= '0;
      else if (idle_reg != IDLE_MAX) idle_reg <= idle_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_SYNC;
      bytes_left_reg   <= '0;
      sum_reg          <= '0;
      filetype_reg     <= '0;
      loader_reset_reg <= 1'b0;
      downloading_reg  <= 1'b0;
      frame_error_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      loader_reset_reg <= 1'b0;
      if (timeout_hit) begin
        frame_error_reg <= 1'b1;
        state_reg       <= S_DRAIN;
      end else if (rx_valid) begin
        case (state_reg)
          S_SYNC: if (rx_data == SYNC_BYTE) begin
            state_reg       <= S_TYPE;
            frame_error_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            bytes_left_reg  <= '0;
            sum_reg         <= '0;
          end
          S_TYPE: begin
            filetype_reg     <= rx_data;
            loader_reset_reg <= 1'b1;
            state_reg        <= S_LEN0;
          end
          S_LEN0: begin
            bytes_left_reg <= len_full;
            state_reg      <= S_LEN1;
          end
          S_LEN1: begin
            bytes_left_reg <= len_full;
            state_reg      <= S_LEN2;
          end
          S_LEN2: begin
            bytes_left_reg <= len_full;
            if (len_full == '0) begin
              state_reg <= S_CSUM;
            end else begin
              downloading_reg <= 1'b1;
              state_reg       <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (fifo_full) overflow_reg <= 1'b1;
            sum_reg <= sum_reg + rx_data;
            if (bytes_left_reg != '0) bytes_left_reg <= bytes_left_reg - 1'b1;
            if (bytes_left_reg == 24'd1) state_reg <= S_CSUM;
          end
          S_CSUM: begin
            if (rx_data != sum_reg) frame_error_reg <= 1'b1;
            state_reg <= S_DRAIN;
          end
          default: ;
        endcase
      end
      // The gap condition keeps the window open until the last write has had its slot.
      if (state_reg == S_DRAIN && fifo_empty && gap_ok) begin
        downloading_reg <= 1'b0;
        state_reg       <= S_SYNC;
      end
    end
  end

  assign loader_reset = loader_reset_reg;
  assign downloading  = downloading_reg;
  assign filetype     = filetype_reg;
  assign is_bios      = filetype_reg[FT_BIOS];
  assign indata_clk   = indata_clk_reg;
  assign frame_error  = frame_error_reg;
  assign overflow     = overflow_reg;
  assign bytes_left   = bytes_left_reg;

endmodule

// File: tb/tb_rom_stream_receiver.sv
// Directed-frame bench: stimulus pushes expected payload bytes into a queue,
// a negedge monitor checks every indata_clk strobe and its spacing.
module tb_rom_stream_receiver;

  localparam int MIN_GAP = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        loader_reset, downloading, is_bios, indata_clk, frame_error, overflow;
  logic [7:0]  filetype, indata;
  logic [23:0] bytes_left;

  rom_stream_receiver #(
    .MIN_GAP(MIN_GAP), .FIFO_DEPTH(16), .TIMEOUT(100), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .loader_reset(loader_reset), .downloading(downloading), .filetype(filetype),
    .is_bios(is_bios), .indata(indata), .indata_clk(indata_clk),
    .frame_error(frame_error), .overflow(overflow), .bytes_left(bytes_left)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_q[$];
  bit         loose = 0, exact_gap = 0, have_last = 0, seen_dl = 0;
  int         pulses = 0, last_pulse = 0, lr_count = 0, fall_cyc = 0;
  logic [7:0] last_data = '0;

  always @(posedge clk) cyc++;

  task automatic check_cond(string name, bit ok, int act, int req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic check(string name, int act, int req);
    check_cond(name, act == req, act, req);
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic send_frame_hdr(logic [7:0] t, logic [23:0] len);
    send_byte(8'hA5);
    send_byte(t);
    send_byte(len[23:16]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask

  task automatic wait_dl_low();
    for (int i = 0; i < 2000 && downloading; i++) @(negedge clk);
    check_cond("dl_fall_bound", !downloading, int'(downloading), 0);
    fall_cyc = cyc;
  endtask

  // Monitor: one line per delivered byte, checked against the scoreboard.
  always @(negedge clk) begin
    if (loader_reset) lr_count++;
    if (downloading) seen_dl = 1;
    if (indata_clk) begin
      pulses++;
      if (have_last) begin
        if (exact_gap) check("gap_exact", cyc - last_pulse, MIN_GAP);
        else check_cond("gap_min", (cyc - last_pulse) >= MIN_GAP, cyc - last_pulse, MIN_GAP);
      end
      have_last  = 1;
      last_pulse = cyc;
      $display("byte cyc=%0d indata=%02h", cyc, indata);
      if (loose) begin
        check_cond("data_order", indata > last_data, int'(indata), int'(last_data) + 1);
        last_data = indata;
      end else if (exp_q.size() == 0) begin
        check_cond("unexpected_pulse", 0, int'(indata), -1);
      end else begin
        check("indata", int'(indata), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pay1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({loader_reset, downloading, filetype, is_bios, indata,
          indata_clk, frame_error, overflow} != 0 || bytes_left != 0), 0);
    reset = 1'b0;

    // Frame with correct checksum, exact pacing
    pulses = 0; lr_count = 0; have_last = 0; exact_gap = 1;
    foreach (pay1[i]) exp_q.push_back(pay1[i]);
    send_frame_hdr(8'h02, 24'd4);
    foreach (pay1[i]) send_byte(pay1[i]);
    send_byte(8'hAA);
    check("t1_frame_error", int'(frame_error), 0);
    check("t1_filetype", int'(filetype), 2);
    check("t1_is_bios", int'(is_bios), 0);
    check("t1_loader_reset_cnt", lr_count, 1);
    wait_dl_low();
    check_cond("t1_dl_tail", (fall_cyc - last_pulse) >= MIN_GAP, fall_cyc - last_pulse, MIN_GAP);
    check("t1_pulses", pulses, 4);
    check("t1_queue_left", exp_q.size(), 0);

    // Same frame, wrong checksum
    pulses = 0; have_last = 0;
    foreach (pay1[i]) exp_q.push_back(pay1[i]);
    send_frame_hdr(8'h02, 24'd4);
    foreach (pay1[i]) send_byte(pay1[i]);
    send_byte(8'h00);
    check("t2_frame_error", int'(frame_error), 1);
    wait_dl_low();
    check("t2_pulses", pulses, 4);
    check("t2_queue_left", exp_q.size(), 0);

    // Long frame overruns the FIFO; its SYNC also clears frame_error
    pulses = 0; have_last = 0; exact_gap = 0; loose = 1; last_data = '0;
    send_byte(8'hA5);
    check("t3_error_cleared", int'(frame_error), 0);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h28);
    check("t3_bytes_left", int'(bytes_left), 40);
    for (int i = 1; i <= 40; i++) send_byte(8'(i));
    check("t3_bytes_left_end", int'(bytes_left), 0);
    send_byte(8'h34);
    check("t3_overflow", int'(overflow), 1);
    check("t3_frame_error", int'(frame_error), 0);
    wait_dl_low();
    check_cond("t3_dropped", pulses < 40 && pulses > 0, pulses, 39);
    loose = 0;

    // Truncated frame, timeout after 100 idle cycles
    pulses = 0; have_last = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h51 + 8'(i));
    send_byte(8'hA5);
    check("t4_overflow_cleared", int'(overflow), 0);
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h51 + 8'(i));
    check("t4_bytes_left", int'(bytes_left), 5);
    repeat (50) @(negedge clk);
    check("t4_no_early_timeout", int'(frame_error), 0);
    repeat (60) @(negedge clk);
    check("t4_timeout_error", int'(frame_error), 1);
    wait_dl_low();
    check("t4_pulses", pulses, 5);
    check("t4_queue_left", exp_q.size(), 0);

    // Garbage then a zero-length BIOS frame
    pulses = 0; lr_count = 0; seen_dl = 0;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    send_frame_hdr(8'h01, 24'd0);
    send_byte(8'h00);
    repeat (20) @(negedge clk);
    check("t5_filetype", int'(filetype), 1);
    check("t5_is_bios", int'(is_bios), 1);
    check("t5_frame_error", int'(frame_error), 0);
    check("t5_no_downloading", int'(seen_dl), 0);
    check("t5_pulses", pulses, 0);
    check("t5_loader_reset_cnt", lr_count, 1);

    // Reset in the middle of a payload, then a fresh frame
    pulses = 0; have_last = 0;
    exp_q.push_back(8'h61);
    send_frame_hdr(8'h02, 24'd8);
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t6_reset_outputs", int'({loader_reset, downloading, filetype, is_bios, indata,
          indata_clk, frame_error, overflow} != 0 || bytes_left != 0), 0);
    repeat (30) @(negedge clk);
    check("t6_pulses_after_reset", pulses, 1);
    exp_q.push_back(8'h7A);
    exp_q.push_back(8'h7B);
    send_frame_hdr(8'h08, 24'd2);
    send_byte(8'h7A);
    send_byte(8'h7B);
    send_byte(8'hF5);
    wait_dl_low();
    check("t6_fresh_pulses", pulses, 3);
    check("t6_fresh_error", int'(frame_error), 0);
    check("t6_fresh_filetype", int'(filetype), 8);
    check("t6_queue_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
